// File: rtl/spram_data_ctrl.sv
// spram_data_ctrl
//   Data-side controller between the CPU load/store port and a 32-bit memory
//   made of two 16Kx16 SPRAMs (upper half on [31:16], lower half on [15:0]).
//   Replicates store data across lanes and builds nibble write masks. Aligns
//   load data and sign- or zero-extends it. Rejects misaligned or illegal
//   accesses. Drops the SPRAMs into standby after IDLE_CYCLES idle cycles and
//   runs a WAKE_CYCLES wake-up delay before the next access.
// Ports
//   clk, rst_n         clock, async active-low reset
//   cpu_req/we/size/unsigned/addr/wdata   request (held until cpu_ack)
//   cpu_ack/err/rdata  one-cycle completion, error flag, load result
//   mem_*              SPRAM pair controls; mem_rdata is DATAOUT
module spram_data_ctrl #(
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [15:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_mask,
    output logic        mem_wren,
    output logic        mem_cs,
    output logic        mem_standby,
    output logic        mem_sleep,
    output logic        mem_poweroff,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR, S_STBY, S_WAKE} state_t;

    localparam int ICW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [ICW-1:0] IDLE_LAST = (IDLE_CYCLES > 0) ? ICW'(IDLE_CYCLES - 1) : '0;
    localparam logic [WCW-1:0] WAKE_LAST = (WAKE_CYCLES > 0) ? WCW'(WAKE_CYCLES - 1) : '0;

    state_t          state, state_d;
    logic [ICW-1:0]  idle_cnt, idle_cnt_d;
    logic [WCW-1:0]  wake_cnt, wake_cnt_d;
    logic            ack_d, err_d, cs_d, wren_d, stby_d;
    logic [13:0]     addr_d;
    logic [31:0]     wdata_d;
    logic [7:0]      mask_d;
    // size/offset/extension of the access in flight, used to shape cpu_rdata
    logic [1:0]      lat_size, lat_size_d;
    logic [1:0]      lat_off, lat_off_d;
    logic            lat_uns, lat_uns_d;

    logic            illegal;
    logic [31:0]     st_data;
    logic [7:0]      st_mask;

    assign mem_sleep    = 1'b0;
    assign mem_poweroff = 1'b1;

    assign illegal = (cpu_size == 2'b11) ||
                     (cpu_size == 2'b01 && cpu_addr[0]) ||
                     (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);

    // Store data is replicated so every lane already holds the value; the
    // mask alone decides which nibbles of which SPRAM get written.
    always_comb begin
        st_data = cpu_wdata;
        st_mask = 8'hFF;
        case (cpu_size)
            2'b00: begin
                st_data = {4{cpu_wdata[7:0]}};
                st_mask = 8'h03 << {cpu_addr[1:0], 1'b0};
            end
            2'b01: begin
                st_data = {2{cpu_wdata[15:0]}};
                st_mask = cpu_addr[1] ? 8'hF0 : 8'h0F;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state;
        idle_cnt_d = idle_cnt;
        wake_cnt_d = wake_cnt;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        cs_d       = 1'b0;
        wren_d     = 1'b0;
        stby_d     = mem_standby;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        mask_d     = mem_mask;
        lat_size_d = lat_size;
        lat_off_d  = lat_off;
        lat_uns_d  = lat_uns;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    // a request in the expiry cycle wins over standby entry
                    idle_cnt_d = '0;
                    if (illegal) begin
                        state_d = S_ERR;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = S_ACCESS;
                        cs_d       = 1'b1;
                        wren_d     = cpu_we;
                        addr_d     = cpu_addr[15:2];
                        wdata_d    = st_data;
                        mask_d     = cpu_we ? st_mask : 8'h00;
                        lat_size_d = cpu_size;
                        lat_off_d  = cpu_addr[1:0];
                        lat_uns_d  = cpu_unsigned;
                    end
                end else if (IDLE_CYCLES != 0 && idle_cnt == IDLE_LAST) begin
                    state_d    = S_STBY;
                    stby_d     = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt + 1'b1;
                end
            end
            S_ACCESS: begin
                // read data appears on mem_rdata during S_RESP
                state_d = S_RESP;
                ack_d   = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            S_STBY: begin
                if (cpu_req) begin
                    state_d    = S_WAKE;
                    stby_d     = 1'b0;
                    wake_cnt_d = '0;
                end
            end
            S_WAKE: begin
                if (wake_cnt == WAKE_LAST) state_d = S_IDLE;
                else                       wake_cnt_d = wake_cnt + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idle_cnt    <= '0;
            wake_cnt    <= '0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            mem_cs      <= 1'b0;
            mem_wren    <= 1'b0;
            mem_standby <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_mask    <= '0;
            lat_size    <= '0;
            lat_off     <= '0;
            lat_uns     <= 1'b0;
        end else begin
            state       <= state_d;
            idle_cnt    <= idle_cnt_d;
            wake_cnt    <= wake_cnt_d;
            cpu_ack     <= ack_d;
            cpu_err     <= err_d;
            mem_cs      <= cs_d;
            mem_wren    <= wren_d;
            mem_standby <= stby_d;
            mem_addr    <= addr_d;
            mem_wdata   <= wdata_d;
            mem_mask    <= mask_d;
            lat_size    <= lat_size_d;
            lat_off     <= lat_off_d;
            lat_uns     <= lat_uns_d;
        end
    end

    // Load alignment and extension straight off SPRAM DATAOUT
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    assign rd_shift = mem_rdata >> {lat_off, 3'b000};
    assign rd_half  = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (lat_size)
            2'b00:   cpu_rdata = {{24{~lat_uns & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   cpu_rdata = {{16{~lat_uns & rd_half[15]}}, rd_half};
            default: cpu_rdata = mem_rdata;
        endcase
    end

endmodule
